// File: rtl/mem.sv
// Memory stage: moves 1, 2 or 4 bytes over an 8-bit RAM port, one byte per
// cycle, holding the upstream stages while the transfer is in progress.
//
// state | meaning
// IDLE  | pass ALU result through, or latch a new access
// XFER  | byte k on the RAM port (store data or load address)
// WAIT  | load only: capture the final byte and commit the result
module mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_mem_e,
  input  logic [31:0] ex_mem_n,
  input  logic [31:0] res,
  input  logic [4:0]  wa,
  input  logic        we,
  output logic [4:0]  wa_o,
  output logic        we_o,
  output logic [31:0] res_o,
  output logic        stall_req,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic [7:0]  mem_din
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  len_q;
  logic        wr_q;
  logic        uns_q;
  logic [4:0]  wa_q;
  logic        we_q;
  logic [31:0] asm_q;

  logic        en;
  logic [1:0]  last_k;
  logic [1:0]  k_inc;
  logic [1:0]  k_dec;
  logic [31:0] asm_full;
  logic [31:0] ld_val;

  assign en     = ex_mem_e[4];
  // len=2 is treated as a word access, same as len=3
  assign last_k = (len_q == 2'd0) ? 2'd0 : (len_q == 2'd1) ? 2'd1 : 2'd3;
  assign k_inc  = k + 2'd1;
  assign k_dec  = k - 2'd1;

  // Final load byte arrives in WAIT and is merged straight into the result.
  always_comb begin
    asm_full = asm_q;
    asm_full[{last_k, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    case (len_q)
      2'd0:    ld_val = uns_q ? {24'b0, asm_full[7:0]}
                              : {{24{asm_full[7]}}, asm_full[7:0]};
      2'd1:    ld_val = uns_q ? {16'b0, asm_full[15:0]}
                              : {{16{asm_full[15]}}, asm_full[15:0]};
      default: ld_val = asm_full;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = XFER;
      XFER:    if (k == last_k) state_nxt = wr_q ? IDLE : WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall drops in the last busy cycle so upstream advances on the commit edge.
  always_comb begin
    stall_req = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    stall_req = en;
        XFER:    stall_req = !(wr_q && (k == last_k));
        default: stall_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      k        <= 2'd0;
      wa_o     <= 5'd0;
      we_o     <= 1'b0;
      res_o    <= 32'd0;
      mem_a    <= 32'd0;
      mem_dout <= 8'd0;
      mem_wr   <= 1'b0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      len_q    <= 2'd0;
      wr_q     <= 1'b0;
      uns_q    <= 1'b0;
      wa_q     <= 5'd0;
      we_q     <= 1'b0;
      asm_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            addr_q   <= res;
            data_q   <= ex_mem_n;
            len_q    <= ex_mem_e[3:2];
            wr_q     <= ex_mem_e[1];
            uns_q    <= ex_mem_e[0];
            wa_q     <= wa;
            we_q     <= we;
            k        <= 2'd0;
            asm_q    <= 32'd0;
            mem_a    <= res;
            mem_dout <= ex_mem_n[7:0];
            mem_wr   <= ex_mem_e[1];
          end else begin
            wa_o   <= wa;
            we_o   <= we;
            res_o  <= res;
            mem_wr <= 1'b0;
          end
        end
        XFER: begin
          if (!wr_q && (k != 2'd0))
            asm_q[{k_dec, 3'b000} +: 8] <= mem_din;
          if (k == last_k) begin
            mem_wr <= 1'b0;
            if (wr_q) begin
              wa_o  <= wa_q;
              we_o  <= 1'b0;
              res_o <= addr_q;
            end
          end else begin
            k        <= k_inc;
            mem_a    <= addr_q + {30'd0, k_inc};
            mem_dout <= data_q[{k_inc, 3'b000} +: 8];
            mem_wr   <= wr_q;
          end
        end
        WAIT: begin
          wa_o   <= wa_q;
          we_o   <= we_q;
          res_o  <= ld_val;
          mem_wr <= 1'b0;
        end
        default: mem_wr <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem.sv
// Scoreboard bench for mem: a byte-array reference model predicts each
// committed result and every RAM write; monitors compare on negedges.
module tb_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  ex_mem_e = '0;
  logic [31:0] ex_mem_n = '0;
  logic [31:0] res = '0;
  logic [4:0]  wa = '0;
  logic        we = 1'b0;
  logic [4:0]  wa_o;
  logic        we_o;
  logic [31:0] res_o;
  logic        stall_req;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din = '0;

  mem dut (
    .clk(clk), .rst(rst), .ex_mem_e(ex_mem_e), .ex_mem_n(ex_mem_n), .res(res),
    .wa(wa), .we(we), .wa_o(wa_o), .we_o(we_o), .res_o(res_o),
    .stall_req(stall_req), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wa;
    logic        we;
    logic [31:0] res;
  } exp_t;

  exp_t        eq[$];
  logic [39:0] wq[$];
  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_ram [logic [31:0]];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_ram[a] = d;
  endtask

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= rd_ram(mem_a);
  end

  logic        p_commit = 1'b0;
  exp_t        m_exp;
  logic [39:0] m_wr;

  always @(negedge clk) begin
    if (p_commit) begin
      n_checks++;
      if (eq.size() == 0) begin
        n_errors++;
        $display("FAIL commit: unexpected result wa_o=%0d we_o=%0b res_o=%h", wa_o, we_o, res_o);
      end else begin
        m_exp = eq.pop_front();
        if ({wa_o, we_o, res_o} !== m_exp) begin
          n_errors++;
          $display("FAIL commit: got wa_o=%0d we_o=%0b res_o=%h, want wa_o=%0d we_o=%0b res_o=%h",
                   wa_o, we_o, res_o, m_exp.wa, m_exp.we, m_exp.res);
        end
      end
    end
    if (mem_wr === 1'b1) begin
      n_checks++;
      if (wq.size() == 0) begin
        n_errors++;
        $display("FAIL ram_write: unexpected write a=%h d=%h", mem_a, mem_dout);
      end else begin
        m_wr = wq.pop_front();
        if ({mem_a, mem_dout} !== m_wr) begin
          n_errors++;
          $display("FAIL ram_write: got a=%h d=%h, want a=%h d=%h",
                   mem_a, mem_dout, m_wr[39:8], m_wr[7:0]);
        end
      end
    end
    p_commit = rst && !stall_req;
  end

  // Presents one upstream op and holds it until the stage advances.
  task automatic issue_op(input logic [4:0] e, input logic [31:0] d, input logic [31:0] r,
                          input logic [4:0] w, input logic wen, output int stalls);
    int          n;
    int          exp_stall;
    exp_t        x;
    logic [31:0] v;
    bit          done;
    n = (e[3:2] == 2'd0) ? 1 : (e[3:2] == 2'd1) ? 2 : 4;
    if (!e[4]) begin
      x = {w, wen, r};
      exp_stall = 0;
    end else if (e[1]) begin
      for (int i = 0; i < n; i++) begin
        wq.push_back({32'(r + i), d[8*i +: 8]});
        ref_ram[32'(r + i)] = d[8*i +: 8];
      end
      x = {w, 1'b0, r};
      exp_stall = n;
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(rd_ref(32'(r + i))) << (8 * i));
      if (!e[0] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      x = {w, wen, v};
      exp_stall = n + 1;
    end
    eq.push_back(x);
    ex_mem_e = e; ex_mem_n = d; res = r; wa = w; we = wen;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall_req) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL stall_timeout: stall_req still %0b after 40 cycles, want 0", stall_req);
    end else if (stalls != exp_stall) begin
      n_errors++;
      $display("FAIL stall_cycles: e=%b got %0d, want %0d", e, stalls, exp_stall);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_checks++;
    if ({wa_o, we_o, res_o, mem_a, mem_dout, mem_wr, stall_req} !== '0) begin
      n_errors++;
      $display("FAIL %s: got wa_o=%0d we_o=%0b res_o=%h mem_a=%h mem_dout=%h mem_wr=%0b stall=%0b, want all 0",
               tag, wa_o, we_o, res_o, mem_a, mem_dout, mem_wr, stall_req);
    end
  endtask

  int          s1, s2;
  logic [4:0]  re;
  logic [31:0] ra;

  initial begin
    for (int i = 0; i < 36; i++) poke(32'h1000 + i, 8'($urandom));
    for (int i = 0; i < 8; i++)  poke(32'hFFFF_FFF8 + i, 8'($urandom));
    for (int i = 0; i < 4; i++)  poke(32'h0 + i, 8'($urandom));
    poke(32'h200, 8'h80);
    poke(32'hFFFF_FFFF, 8'h34);
    poke(32'h0, 8'h12);
    poke(32'h1, 8'h00);

    ex_mem_e = 5'h10;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    rst = 1'b1;

    issue_op(5'b00000, 32'h0, 32'h1234, 5'd5, 1'b1, s1);
    issue_op(5'b11110, 32'hA1B2_C3D4, 32'h100, 5'd7, 1'b1, s1);
    issue_op(5'b10000, 32'h0, 32'h200, 5'd3, 1'b1, s1);
    issue_op(5'b10001, 32'h0, 32'h200, 5'd4, 1'b1, s1);
    issue_op(5'b10100, 32'h0, 32'hFFFF_FFFF, 5'd9, 1'b1, s1);
    issue_op(5'b11000, 32'h0, 32'h100, 5'd2, 1'b1, s1);

    // Reset lands in T2 of a word store; bytes 0 and 1 already reached RAM.
    ex_mem_e = 5'b11110; ex_mem_n = 32'h5566_7788; res = 32'h1008; wa = 5'd1; we = 1'b1;
    for (int i = 0; i < 4; i++) wq.push_back({32'h1008 + 32'(i), 8'(32'h5566_7788 >> (8 * i))});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stall_req !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_in_reset: got %0b, want 0", stall_req);
    end
    @(posedge clk); #1;
    check_zero_outputs("reset_mid_store");
    wq.delete();
    ref_ram[32'h1008] = 8'h88;
    ref_ram[32'h1009] = 8'h77;
    rst = 1'b1;
    issue_op(5'b11100, 32'h0, 32'h1008, 5'd6, 1'b1, s1);

    issue_op(5'b11110, 32'hDEAD_BEEF, 32'h10, 5'd8, 1'b1, s1);
    issue_op(5'b11100, 32'h0, 32'h10, 5'd10, 1'b1, s2);
    n_checks++;
    if (s1 + s2 != 9) begin
      n_errors++;
      $display("FAIL back_to_back_cycles: got %0d, want 9", s1 + s2);
    end

    for (int t = 0; t < 80; t++) begin
      re = {($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 2'($urandom), 1'($urandom), 1'($urandom)};
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                       : 32'h1000 + $urandom_range(0, 31);
      if (!re[4]) ra = $urandom;
      issue_op(re, $urandom, ra, 5'($urandom), 1'($urandom), s1);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (eq.size() != 0 || wq.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d results and %0d writes pending, want 0 and 0", eq.size(), wq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
